// File: rtl/branch_target_buffer_pkg.sv
// rtl/branch_target_buffer_pkg.sv - shared constants and counter-encoding helpers for the BTB
package branch_target_buffer_pkg;

  localparam int PC_W      = 32;
  localparam int MAX_CTR_W = 4;

  // Weakly-taken: MSB set, lower bits clear.
  function automatic logic [MAX_CTR_W-1:0] btb_ctr_wt(input int w);
    return MAX_CTR_W'(1) << (w - 1);
  endfunction

  // Weakly-not-taken: MSB clear, lower bits set.
  function automatic logic [MAX_CTR_W-1:0] btb_ctr_wnt(input int w);
    return (MAX_CTR_W'(1) << (w - 1)) - MAX_CTR_W'(1);
  endfunction

endpackage

// File: rtl/btb_sat_ctr.sv
// rtl/btb_sat_ctr.sv - next value of a CTR_W-bit saturating up/down direction counter
module btb_sat_ctr #(
  parameter int CTR_W = 2
) (
  input  logic [CTR_W-1:0] ctr_i,
  input  logic             inc_i,
  output logic [CTR_W-1:0] ctr_o
);

  localparam logic [CTR_W-1:0] CTR_MAX = '1;

  always_comb begin
    ctr_o = ctr_i;
    if (inc_i) begin
      if (ctr_i != CTR_MAX) ctr_o = ctr_i + CTR_W'(1);
    end else begin
      if (ctr_i != '0) ctr_o = ctr_i - CTR_W'(1);
    end
  end

endmodule

// File: rtl/branch_target_buffer.sv
// rtl/branch_target_buffer.sv - direct-mapped BTB with saturating direction counters,
// combinational lookup, execute-stage repair, misprediction detect and statistics.
module branch_target_buffer
  import branch_target_buffer_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2,
  parameter int CNT_W   = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [PC_W-1:0]  lk_pc,
  input  logic             lk_valid,
  output logic             pred_taken,
  output logic [PC_W-1:0]  pred_pc,
  input  logic             upd_valid,
  input  logic [PC_W-1:0]  upd_pc,
  input  logic             upd_taken,
  input  logic [PC_W-1:0]  upd_target,
  input  logic             upd_pred_taken,
  input  logic [PC_W-1:0]  upd_pred_pc,
  output logic             mispredict,
  output logic [PC_W-1:0]  correct_pc,
  input  logic             inval_all,
  output logic [CNT_W-1:0] lookups,
  output logic [CNT_W-1:0] mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - 2 - IDX_W;
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(btb_ctr_wt(CTR_W));
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'(btb_ctr_wnt(CTR_W));

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [PC_W-1:0]  target;
    logic [CTR_W-1:0] ctr;
  } btb_entry_t;

  btb_entry_t       tbl_q [ENTRIES];
  btb_entry_t       tbl_d [ENTRIES];
  logic [CTR_W-1:0] ctr_nxt [ENTRIES];
  logic [CNT_W-1:0] lookups_q, lookups_d;
  logic [CNT_W-1:0] mispredicts_q, mispredicts_d;

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic             lk_hit, upd_hit;
  logic             unused_in_bits;

  assign lk_idx  = lk_pc[IDX_W+1:2];
  assign lk_tag  = lk_pc[PC_W-1:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[PC_W-1:IDX_W+2];

  // The carried prediction bit is redundant with upd_pred_pc for detection purposes.
  assign unused_in_bits = ^{lk_pc[1:0], upd_pc[1:0], upd_pred_taken};

  assign lk_hit     = tbl_q[lk_idx].valid && (tbl_q[lk_idx].tag == lk_tag);
  assign pred_taken = lk_hit && tbl_q[lk_idx].ctr[CTR_W-1];
  assign pred_pc    = pred_taken ? tbl_q[lk_idx].target : lk_pc + PC_W'(4);

  assign upd_hit    = tbl_q[upd_idx].valid && (tbl_q[upd_idx].tag == upd_tag);
  assign correct_pc = upd_taken ? upd_target : upd_pc + PC_W'(4);
  assign mispredict = upd_valid && (upd_pred_pc != correct_pc);

  for (genvar g = 0; g < ENTRIES; g++) begin : g_ctr
    btb_sat_ctr #(.CTR_W(CTR_W)) u_sat_ctr (
      .ctr_i (tbl_q[g].ctr),
      .inc_i (upd_taken),
      .ctr_o (ctr_nxt[g])
    );
  end

  always_comb begin
    tbl_d = tbl_q;
    if (inval_all) begin
      for (int i = 0; i < ENTRIES; i++) tbl_d[i].valid = 1'b0;
    end else if (upd_valid) begin
      if (upd_hit) begin
        tbl_d[upd_idx].ctr = ctr_nxt[upd_idx];
        if (upd_taken) tbl_d[upd_idx].target = upd_target;
      end else if (upd_taken) begin
        tbl_d[upd_idx] = '{valid: 1'b1, tag: upd_tag, target: upd_target, ctr: CTR_WT};
      end
    end
  end

  always_comb begin
    lookups_d     = lookups_q;
    mispredicts_d = mispredicts_q;
    if (lk_valid && (lookups_q != '1))       lookups_d     = lookups_q + CNT_W'(1);
    if (mispredict && (mispredicts_q != '1)) mispredicts_d = mispredicts_q + CNT_W'(1);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};
      end
      lookups_q     <= '0;
      mispredicts_q <= '0;
    end else begin
      tbl_q         <= tbl_d;
      lookups_q     <= lookups_d;
      mispredicts_q <= mispredicts_d;
    end
  end

  assign lookups     = lookups_q;
  assign mispredicts = mispredicts_q;

endmodule

// File: tb/tb_branch_target_buffer.sv
// tb/tb_branch_target_buffer.sv - self-checking bench for branch_target_buffer
module tb_branch_target_buffer;

  localparam int ENTRIES = 16;
  localparam int IDX_W   = 4;
  localparam int CTR_W   = 2;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = 255;
  localparam int CTR_MAX = 3;
  localparam int CTR_THR = 2;

  logic             CLK = 1'b0;
  logic             nRST = 1'b0;
  logic [31:0]      lk_pc = '0;
  logic             lk_valid = 1'b0;
  logic             pred_taken;
  logic [31:0]      pred_pc;
  logic             upd_valid = 1'b0;
  logic [31:0]      upd_pc = '0;
  logic             upd_taken = 1'b0;
  logic [31:0]      upd_target = '0;
  logic             upd_pred_taken = 1'b0;
  logic [31:0]      upd_pred_pc = '0;
  logic             mispredict;
  logic [31:0]      correct_pc;
  logic             inval_all = 1'b0;
  logic [CNT_W-1:0] lookups;
  logic [CNT_W-1:0] mispredicts;

  int n_cmp = 0;
  int n_fail = 0;

  branch_target_buffer #(.ENTRIES(ENTRIES), .CTR_W(CTR_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST),
    .lk_pc(lk_pc), .lk_valid(lk_valid), .pred_taken(pred_taken), .pred_pc(pred_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_pc(upd_pred_pc),
    .mispredict(mispredict), .correct_pc(correct_pc), .inval_all(inval_all),
    .lookups(lookups), .mispredicts(mispredicts)
  );

  always #5 CLK = ~CLK;

  // Reference model: table as plain arrays, counters as integers.
  bit          m_valid [ENTRIES];
  logic [31:0] m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  int          m_lookups, m_misp;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc >> (2 + IDX_W);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
  endfunction

  function automatic bit m_taken(input logic [31:0] pc);
    return m_hit(pc) && (m_ctr[idx_of(pc)] >= CTR_THR);
  endfunction

  function automatic logic [31:0] m_pred(input logic [31:0] pc);
    return m_taken(pc) ? m_tgt[idx_of(pc)] : pc + 32'd4;
  endfunction

  function automatic logic [31:0] m_correct();
    return upd_taken ? upd_target : upd_pc + 32'd4;
  endfunction

  function automatic bit m_misp_now();
    return upd_valid && (upd_pred_pc != m_correct());
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = CTR_THR - 1;
    end
    m_lookups = 0; m_misp = 0;
  endfunction

  function automatic void m_clock();
    int i;
    i = idx_of(upd_pc);
    if (lk_valid && m_lookups < CNT_MAX) m_lookups++;
    if (m_misp_now() && m_misp < CNT_MAX) m_misp++;
    if (inval_all) begin
      for (int k = 0; k < ENTRIES; k++) m_valid[k] = 0;
    end else if (upd_valid) begin
      if (m_hit(upd_pc)) begin
        if (upd_taken) begin
          m_ctr[i] = (m_ctr[i] < CTR_MAX) ? m_ctr[i] + 1 : CTR_MAX;
          m_tgt[i] = upd_target;
        end else begin
          m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        end
      end else if (upd_taken) begin
        m_valid[i] = 1; m_tag[i] = tag_of(upd_pc); m_tgt[i] = upd_target; m_ctr[i] = CTR_THR;
      end
    end
  endfunction

  task automatic idle();
    lk_valid = 0; upd_valid = 0; upd_taken = 0; upd_pred_taken = 0; inval_all = 0;
  endtask

  task automatic tick();
    @(posedge CLK);
    m_clock();
    #1;
  endtask

  task automatic set_upd(input logic [31:0] pc, input bit tk, input logic [31:0] tgt,
                         input logic [31:0] ppc);
    upd_valid = 1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
    upd_pred_pc = ppc; upd_pred_taken = (ppc != pc + 32'd4);
  endtask

  task automatic test_reset();
    m_reset();
    lk_pc = 32'h40;
    repeat (3) @(posedge CLK);
    #1 nRST = 1;
    #2;
    n_cmp += 4;
    if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL reset_pred_taken got %h exp 0", pred_taken); end
    if (pred_pc !== 32'h44) begin n_fail++; $display("FAIL reset_pred_pc got %h exp 44", pred_pc); end
    if (lookups !== '0) begin n_fail++; $display("FAIL reset_lookups got %h exp 0", lookups); end
    if (mispredicts !== '0) begin n_fail++; $display("FAIL reset_mispredicts got %h exp 0", mispredicts); end
    lk_pc = 32'hFFFF_FFFC;
    #1;
    n_cmp++;
    if (pred_pc !== 32'h0) begin n_fail++; $display("FAIL reset_wrap_pc got %h exp 0", pred_pc); end
    tick();
  endtask

  task automatic test_alloc();
    idle();
    set_upd(32'h40, 1, 32'h100, 32'h44);
    #2;
    n_cmp += 2;
    if (mispredict !== 1'b1) begin n_fail++; $display("FAIL alloc_mispredict got %h exp 1", mispredict); end
    if (correct_pc !== 32'h100) begin n_fail++; $display("FAIL alloc_correct_pc got %h exp 100", correct_pc); end
    tick();
    idle(); lk_pc = 32'h40; lk_valid = 1;
    #2;
    n_cmp += 3;
    if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL alloc_pred_taken got %h exp 1", pred_taken); end
    if (pred_pc !== 32'h100) begin n_fail++; $display("FAIL alloc_pred_pc got %h exp 100", pred_pc); end
    if (mispredicts !== 8'd1) begin n_fail++; $display("FAIL alloc_mispredicts got %h exp 1", mispredicts); end
    tick();
    idle();
    #2;
    n_cmp++;
    if (lookups !== 8'd1) begin n_fail++; $display("FAIL alloc_lookups got %h exp 1", lookups); end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 4; i++) begin
      idle(); set_upd(32'h40, 0, 32'h0, 32'h44);
      tick();
    end
    idle(); lk_pc = 32'h40;
    #2;
    n_cmp += 2;
    if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL sat_low_taken got %h exp 0", pred_taken); end
    if (pred_pc !== 32'h44) begin n_fail++; $display("FAIL sat_low_pc got %h exp 44", pred_pc); end
    set_upd(32'h40, 1, 32'h100, 32'h44);
    tick();
    idle(); lk_pc = 32'h40;
    #2;
    n_cmp++;
    if (pred_pc !== 32'h44) begin n_fail++; $display("FAIL sat_one_up_pc got %h exp 44", pred_pc); end
    set_upd(32'h40, 1, 32'h100, 32'h44);
    tick();
    idle(); lk_pc = 32'h40;
    #2;
    n_cmp++;
    if (pred_pc !== 32'h100) begin n_fail++; $display("FAIL sat_two_up_pc got %h exp 100", pred_pc); end
  endtask

  task automatic test_alias();
    idle(); set_upd(32'h80, 1, 32'h300, 32'h84);
    tick();
    idle(); lk_pc = 32'h40;
    #2;
    n_cmp++;
    if (pred_pc !== 32'h44) begin n_fail++; $display("FAIL alias_old_pc got %h exp 44", pred_pc); end
    lk_pc = 32'h80;
    #1;
    n_cmp += 2;
    if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL alias_new_taken got %h exp 1", pred_taken); end
    if (pred_pc !== 32'h300) begin n_fail++; $display("FAIL alias_new_pc got %h exp 300", pred_pc); end
    tick();
  endtask

  task automatic test_rbw();
    idle(); set_upd(32'h40, 1, 32'h500, 32'h44); lk_pc = 32'h40;
    #2;
    n_cmp++;
    if (pred_pc !== 32'h44) begin n_fail++; $display("FAIL rbw_same_cycle got %h exp 44", pred_pc); end
    tick();
    idle();
    #2;
    n_cmp++;
    if (pred_pc !== 32'h500) begin n_fail++; $display("FAIL rbw_next_cycle got %h exp 500", pred_pc); end
  endtask

  task automatic test_inval();
    idle(); set_upd(32'h1000_0008, 1, 32'h700, 32'h1000_000C); inval_all = 1;
    tick();
    idle(); lk_pc = 32'h1000_0008;
    #2;
    n_cmp++;
    if (pred_pc !== 32'h1000_000C) begin n_fail++; $display("FAIL inval_no_alloc got %h exp 1000000c", pred_pc); end
    lk_pc = 32'h40;
    #1;
    n_cmp++;
    if (pred_pc !== 32'h44) begin n_fail++; $display("FAIL inval_cleared got %h exp 44", pred_pc); end
    tick();
  endtask

  task automatic test_stale_target();
    idle(); set_upd(32'h240, 1, 32'h100, 32'h244);
    tick();
    idle(); set_upd(32'h240, 1, 32'h200, 32'h100);
    #2;
    n_cmp += 2;
    if (mispredict !== 1'b1) begin n_fail++; $display("FAIL stale_mispredict got %h exp 1", mispredict); end
    if (correct_pc !== 32'h200) begin n_fail++; $display("FAIL stale_correct_pc got %h exp 200", correct_pc); end
    tick();
    idle(); lk_pc = 32'h240;
    #2;
    n_cmp++;
    if (pred_pc !== 32'h200) begin n_fail++; $display("FAIL stale_retarget got %h exp 200", pred_pc); end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] pc;
    for (int c = 0; c < 400; c++) begin
      idle();
      lk_pc = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
      lk_valid = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 2) != 0) begin
        pc = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
        if ($urandom_range(0, 3) == 0) pc = lk_pc;
        upd_valid = 1; upd_pc = pc; upd_taken = $urandom_range(0, 1) == 1;
        upd_target = $urandom & 32'hFFFF_FFFC;
        if ($urandom_range(0, 3) == 0) upd_target = m_tgt[idx_of(pc)];
        upd_pred_taken = m_taken(pc);
        upd_pred_pc = ($urandom_range(0, 3) != 0) ? m_pred(pc) : ($urandom & 32'hFFFF_FFFC);
      end
      inval_all = $urandom_range(0, 40) == 0;
      #2;
      n_cmp += 6;
      if (pred_taken !== m_taken(lk_pc)) begin n_fail++; $display("FAIL rnd_pred_taken c=%0d got %h exp %h", c, pred_taken, m_taken(lk_pc)); end
      if (pred_pc !== m_pred(lk_pc)) begin n_fail++; $display("FAIL rnd_pred_pc c=%0d got %h exp %h", c, pred_pc, m_pred(lk_pc)); end
      if (mispredict !== m_misp_now()) begin n_fail++; $display("FAIL rnd_mispredict c=%0d got %h exp %h", c, mispredict, m_misp_now()); end
      if (correct_pc !== m_correct()) begin n_fail++; $display("FAIL rnd_correct_pc c=%0d got %h exp %h", c, correct_pc, m_correct()); end
      if (lookups !== CNT_W'(m_lookups)) begin n_fail++; $display("FAIL rnd_lookups c=%0d got %0d exp %0d", c, lookups, m_lookups); end
      if (mispredicts !== CNT_W'(m_misp)) begin n_fail++; $display("FAIL rnd_mispredicts c=%0d got %0d exp %0d", c, mispredicts, m_misp); end
      tick();
    end
  endtask

  task automatic test_stat_saturate();
    idle();
    set_upd(32'h7000_0000, 0, 32'h0, 32'h0);
    lk_valid = 1; lk_pc = 32'h4;
    repeat (300) tick();
    #1;
    n_cmp += 2;
    if (mispredicts !== 8'hFF) begin n_fail++; $display("FAIL sat_mispredicts got %h exp ff", mispredicts); end
    if (lookups !== 8'hFF) begin n_fail++; $display("FAIL sat_lookups got %h exp ff", lookups); end
    tick();
    #1;
    n_cmp++;
    if (mispredicts !== 8'hFF) begin n_fail++; $display("FAIL sat_hold got %h exp ff", mispredicts); end
  endtask

  task automatic test_reset_mid_update();
    idle(); set_upd(32'h4, 1, 32'h900, 32'h8);
    #2 nRST = 0;
    @(posedge CLK);
    #1;
    idle(); nRST = 1; m_reset(); lk_pc = 32'h4;
    #2;
    n_cmp += 3;
    if (pred_pc !== 32'h8) begin n_fail++; $display("FAIL rst_mid_upd_pc got %h exp 8", pred_pc); end
    if (mispredicts !== '0) begin n_fail++; $display("FAIL rst_mid_mispredicts got %h exp 0", mispredicts); end
    if (lookups !== '0) begin n_fail++; $display("FAIL rst_mid_lookups got %h exp 0", lookups); end
    tick();
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_saturate();
    test_alias();
    test_rbw();
    test_inval();
    test_stale_target();
    test_random();
    test_stat_saturate();
    test_reset_mid_update();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_target_buffer.md
# branch_target_buffer

Parametrised direct-mapped branch target buffer with per-entry saturating direction counters. Predicts the next fetch PC in the fetch stage and repairs itself from resolved branches and jumps in the execute stage. It also flags mispredictions and supplies the corrected PC, so the hazard unit can flush fetch/decode. It removes the fixed "always PC+4, flush on taken" policy of the current pipeline.

## Interface
Parameters:
- ENTRIES, 16, number of entries; power of two, 2..256; IDX_W = $clog2(ENTRIES)
- CTR_W, 2, direction counter width; 1..4
- CNT_W, 32, width of the statistics counters

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- lk_pc  in  32  fetch PC (word aligned)
- lk_valid  in  1  fetch stage advancing this cycle (ihit & !stall); qualifies statistics only
- pred_taken  out  1  predicted taken for lk_pc
- pred_pc  out  32  predicted next PC: stored target if pred_taken, else lk_pc+4
- upd_valid  in  1  resolved control-transfer instruction in execute, asserted for exactly one cycle per instruction
- upd_pc  in  32  PC of the resolved instruction
- upd_taken  in  1  actual outcome (jumps always 1)
- upd_target  in  32  actual target
- upd_pred_taken  in  1  prediction carried down the pipe with the instruction
- upd_pred_pc  in  32  predicted next PC carried down the pipe
- mispredict  out  1  upd_valid and upd_pred_pc != actual next PC
- correct_pc  out  32  upd_taken ? upd_target : upd_pc+4
- inval_all  in  1  synchronous invalidate of every entry
- lookups  out  CNT_W  count of lk_valid cycles
- mispredicts  out  CNT_W  count of mispredict cycles

## Operation
- Index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]. Each entry holds valid, tag, target[31:0] and ctr[CTR_W-1:0]. The counter MSB=1 means taken.
- Lookup is combinational. A hit is valid & tag match. pred_taken = hit & ctr MSB. pred_pc = pred_taken ? target : lk_pc+4. Adds wrap modulo 2^32.
- Update when upd_valid, with hit computed on upd_pc:
  - Hit, taken: ctr saturating increment (stops at all-ones); target <= upd_target.
  - Hit, not taken: ctr saturating decrement (stops at 0); target unchanged.
  - Miss, taken: allocate by overwriting the indexed entry. Set valid=1, new tag, target, and ctr = weakly taken (MSB=1, rest 0).
  - Miss, not taken: no change.
- mispredict compares the full next PC, which also catches taken-with-stale-target. It is independent of the table state.
- inval_all clears all valid bits; counters and targets are untouched. If inval_all and upd_valid occur in the same cycle, inval_all wins and no allocation happens.
- Statistics counters saturate at all-ones and never wrap.

## Timing
- Lookup latency 0 cycles: combinational from lk_pc.
- Updates are written at the rising edge ending the upd_valid cycle and are visible to lookups in the next cycle.
- If the same index is looked up and updated in one cycle, the lookup returns the pre-update contents (read-before-write).
- mispredict and correct_pc are combinational from update inputs, in the same cycle as upd_valid.
- Reset (async, nRST low): all valid=0; all ctr = weakly not-taken (MSB=0, rest 1); targets and tags 0; lookups=mispredicts=0.
- After reset every lookup gives pred_taken=0 and pred_pc=lk_pc+4.
- A reset asserted mid-update discards that update.
- There is no stall input. The caller gates upd_valid and lk_valid with pipeline advance; a held upd_valid counts as repeated updates.

## Structure
- Add to cpu_types_pkg:
  - btb_entry_t, a packed struct holding valid, tag, target and ctr, sized from parameters via a localparam-driven typedef inside the module.
  - BTB_CTR_WT / BTB_CTR_WNT helper functions, or equivalent constants for the CTR_W=2 default.
- One natural sub-module: btb_sat_ctr, a CTR_W-bit saturating up/down next-value function/module used per entry.
- Storage is flip-flops (array of btb_entry_t), not SRAM.

## Test plan
- Reset then lookup lk_pc=0x0000_0040 -> pred_taken=0, pred_pc=0x44; lookups, mispredicts = 0.
- Update upd_pc=0x40, taken, target 0x100, upd_pred_pc=0x44 -> mispredict=1, correct_pc=0x100. Next cycle lookup 0x40 -> pred_taken=1, pred_pc=0x100; mispredicts=1.
- Four not-taken updates of 0x40 after allocation -> counter reaches 0 and saturates there. Lookup gives pred_pc=0x44; one taken update restores ctr=1 and still predicts not-taken.
- Aliasing (ENTRIES=16): allocate 0x40, then taken update of 0x80 (same index, different tag) -> 0x40 now misses; 0x80 predicts its target.
- Same-cycle lookup and update at 0x40 -> lookup shows old prediction; the new one appears next cycle. Separately, inval_all together with a taken update of a new PC -> no entry is allocated.
- Taken update with correct direction but stale target (predicted 0x100, actual 0x200) -> mispredict=1, correct_pc=0x200. Force mispredicts to all-ones -> it holds at all-ones.
